me_sched: RTL

ME_SCHED -- requirements
Module: me_sched

---
 rtl/me_pkg.sv | 29 ++
 rtl/me_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/me_pkg.sv
// me_pkg: scheduler state encoding, block geometry and watchdog constants shared by me_sched.
package me_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        LOAD_REF,
        GO,
        WAIT_DONE,
        RESULT
    } state_t;

    localparam int         CUR_WORDS         = 32;
    localparam int         REF_WORDS         = 128;
    localparam int         ME_TIMEOUT_CYCLES = 4096;
    localparam logic [7:0] MV_INVALID        = 8'h80;

    localparam int WORD_CNT_W = $clog2(REF_WORDS);
    localparam int TMO_CNT_W  = $clog2(ME_TIMEOUT_CYCLES);

    // The final word index differs per load phase; one counter serves both.
    function automatic logic isLastWord(input state_t st, input logic [WORD_CNT_W-1:0] cnt);
        if (st == LOAD_CUR) begin
            return cnt == WORD_CNT_W'(CUR_WORDS - 1);
        end
        return cnt == WORD_CNT_W'(REF_WORDS - 1);
    endfunction

endpackage

// File: rtl/me_sched.sv
// me_sched: streams one macroblock (32 current + 128 reference words) into the engine RAMs,
// fires the search and returns the motion vector. Define ME_SCHED_TIMEOUT_EN for a search watchdog.
module me_sched
    import me_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  r_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic [1:0]  r,
    output logic        go,
    output logic        write_enable_cur,
    output logic [4:0]  address_write_cur,
    output logic [63:0] data_write_cur,
    output logic        write_enable_ref,
    output logic [6:0]  address_write_ref,
    output logic [63:0] data_write_ref,
    input  logic        done,
    input  logic [7:0]  m_i,
    input  logic [7:0]  m_j,
    output logic        mv_valid,
    input  logic        mv_ready,
    output logic [7:0]  mv_i,
    output logic [7:0]  mv_j,
    output logic [15:0] blk_cnt,
`ifdef ME_SCHED_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic        busy
);

    state_t                r_state;
    logic [WORD_CNT_W-1:0] r_cnt;
    logic [1:0]            r_r;
    logic                  r_inReady;
    logic                  r_go;
    logic                  r_weCur;
    logic                  r_weRef;
    logic [6:0]            r_wAddr;
    logic [63:0]           r_wData;
    logic                  r_mvValid;
    logic [7:0]            r_mvI;
    logic [7:0]            r_mvJ;
    logic [15:0]           r_blkCnt;
    logic                  r_busy;
`ifdef ME_SCHED_TIMEOUT_EN
    logic [TMO_CNT_W-1:0]  r_tcnt;
    logic                  r_timeout;
`endif

    logic w_xfer;
    logic w_lastWord;
    logic w_handshake;

    assign w_xfer      = in_valid && r_inReady;
    assign w_lastWord  = isLastWord(r_state, r_cnt);
    assign w_handshake = r_mvValid && mv_ready;

    // The word counter and the write-port register are shared by both load phases;
    // only the enable bit tells the two RAMs apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_r       <= '0;
            r_inReady <= 1'b0;
            r_go      <= 1'b0;
            r_weCur   <= 1'b0;
            r_weRef   <= 1'b0;
            r_wAddr   <= '0;
            r_wData   <= '0;
            r_mvValid <= 1'b0;
            r_mvI     <= '0;
            r_mvJ     <= '0;
            r_blkCnt  <= '0;
            r_busy    <= 1'b0;
`ifdef ME_SCHED_TIMEOUT_EN
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_weCur <= 1'b0;
            r_weRef <= 1'b0;
            r_go    <= 1'b0;
`ifdef ME_SCHED_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (w_xfer) begin
                r_weCur <= (r_state == LOAD_CUR);
                r_weRef <= (r_state == LOAD_REF);
                r_wAddr <= r_cnt;
                r_wData <= in_data;
                r_cnt   <= w_lastWord ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_r       <= r_in;
                        r_inReady <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= LOAD_CUR;
                    end
                end
                LOAD_CUR: begin
                    if (w_xfer && w_lastWord) begin
                        r_state <= LOAD_REF;
                    end
                end
                LOAD_REF: begin
                    if (w_xfer && w_lastWord) begin
                        r_inReady <= 1'b0;
                        r_state   <= GO;
                    end
                end
                GO: begin
                    r_go    <= 1'b1;
                    r_state <= WAIT_DONE;
`ifdef ME_SCHED_TIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                end
                WAIT_DONE: begin
                    // done may still be high from the previous search during the go cycle.
                    if (!r_go) begin
                        if (done) begin
                            r_mvI     <= m_i;
                            r_mvJ     <= m_j;
                            r_mvValid <= 1'b1;
                            r_state   <= RESULT;
                        end
`ifdef ME_SCHED_TIMEOUT_EN
                        else if (r_tcnt == TMO_CNT_W'(ME_TIMEOUT_CYCLES - 1)) begin
                            r_mvI     <= MV_INVALID;
                            r_mvJ     <= MV_INVALID;
                            r_mvValid <= 1'b1;
                            r_timeout <= 1'b1;
                            r_state   <= RESULT;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
`endif
                    end
                end
                RESULT: begin
                    if (w_handshake) begin
                        r_blkCnt  <= r_blkCnt + 1'b1;
                        r_mvValid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready          = r_inReady;
    assign r                 = r_r;
    assign go                = r_go;
    assign write_enable_cur  = r_weCur;
    assign address_write_cur = r_wAddr[4:0];
    assign data_write_cur    = r_wData;
    assign write_enable_ref  = r_weRef;
    assign address_write_ref = r_wAddr;
    assign data_write_ref    = r_wData;
    assign mv_valid          = r_mvValid;
    assign mv_i              = r_mvI;
    assign mv_j              = r_mvJ;
    assign blk_cnt           = r_blkCnt;
    assign busy              = r_busy;
`ifdef ME_SCHED_TIMEOUT_EN
    assign timeout           = r_timeout;
`endif

endmodule
